clock_ratio_meter: RTL and testbench
====================================

# clock_ratio_meter

Measures the period and high time of a divided clock, in cycles of the reference clock that generated it. It is the receiving counterpart of the team's programmable clock divider: it reads back the division ratio and duty from the divided output, and flags lock and loss of activity. It is used for self-check of divider settings and for monitoring derived clocks in the clock subsystem.

## Interface
- SYNC_STAGES, 2: synchroniser depth on `sig_in`; legal values are 2 or more.
- WIDTH, 32: width of the measurement counters and outputs.
- TIMEOUT, 2**20: number of cycles without a rising edge before `timeout` asserts; must be less than 2**WIDTH.

Ports:
- clk_in  input  1  reference clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = measure; 0 = idle.
- sig_in  input  1  monitored divided clock; treated as asynchronous.
- ratio  output  WIDTH  last measured period, in clk_in cycles (rise to rise).
- high_cnt  output  WIDTH  clk_in cycles the signal was high in the last period.
- valid  output  1  one-cycle pulse when `ratio`/`high_cnt` update.
- locked  output  1  two consecutive identical measurements.
- timeout  output  1  no rising edge seen for TIMEOUT cycles.

## Operation
- `sig_in` passes through a SYNC_STAGES flop chain, then one delay flop.
- `rise` = synchronised level AND NOT delayed level.
- States:
  - IDLE: entered from reset, or whenever `enable` = 0. Counters are cleared; `locked` and `timeout` are cleared; `ratio` and `high_cnt` hold their values. Leaves to WAIT_EDGE when `enable` = 1.
  - WAIT_EDGE: `per_cnt` increments, saturating at TIMEOUT. On `rise`: `per_cnt` := 1, `hi_cnt` := 1, `timeout` := 0, go to MEASURE. No `valid` is produced here, because the period is partial.
  - MEASURE: `per_cnt` += 1 each cycle. `hi_cnt` += the synchronised level. On `rise`:
    - `ratio` := `per_cnt` and `high_cnt` := `hi_cnt`;
    - `valid` := 1;
    - both counters reload to 1.
  - MEASURE timeout: when `per_cnt` reaches TIMEOUT, `timeout` := 1, `locked` := 0, go to WAIT_EDGE with `per_cnt` held at TIMEOUT.
- `locked`:
  - set on a `valid` whose new `ratio` and `high_cnt` both equal the previous pair;
  - cleared on a mismatching `valid`, on timeout, and in IDLE.
- `enable` falling mid-period discards the partial period and goes to IDLE the next cycle.
- For a divider of ratio N (N ≥ 2): `ratio` = N, `high_cnt` = N − floor(N/2).
- Ratios below 2 and pulses shorter than one clk_in cycle are unsupported.
- Counter widths are WIDTH. `per_cnt` never wraps because it saturates at TIMEOUT.

## Timing
- Reset values: `ratio` = 0, `high_cnt` = 0, `valid` = 0, `locked` = 0, `timeout` = 0; state = IDLE.
- Reset mid-operation returns everything to the reset values immediately (asynchronous).
- Latency: if `sig_in` is first sampled high at edge k, `valid` is high in the cycle after edge k+SYNC_STAGES.
- `locked` updates on the same edge as `valid`.
- `timeout` asserts on the edge where `per_cnt` reaches TIMEOUT.
- Simultaneous `rise` and TIMEOUT: `rise` wins; the measurement is accepted.
- Simultaneous `rise` and `enable` = 0: IDLE wins; no `valid`.

## Structure
- Package `clock_ratio_pkg`: state enum {IDLE, WAIT_EDGE, MEASURE}, and the default SYNC_STAGES/WIDTH/TIMEOUT constants.
- Sub-module `sync_rise_detect`: synchroniser chain, delay flop, and `rise`/level outputs; parameterised by SYNC_STAGES.
- The top level holds the FSM, counters, capture registers and lock compare.

## Test plan
- Divider N=4, `enable` = 1 → first `valid` after the second rise, then every 4 cycles. `ratio` = 4, `high_cnt` = 2. `locked` = 1 on the second `valid`.
- Divider N=5 → `ratio` = 5, `high_cnt` = 3, `locked` after two `valid`s. Divider N=2 → `ratio` = 2, `high_cnt` = 1.
- Locked at N=4, switch to N=6 → `locked` drops on the first 6-cycle `valid` and re-asserts on the next one. `ratio` = 6, `high_cnt` = 3.
- TIMEOUT=64, `sig_in` held low after lock → `timeout` = 1 exactly 64 cycles after the last rise counted; `locked` = 0. The next rise clears `timeout` with no `valid`.
- Async `reset` pulse mid-period → all outputs 0 immediately. Measurement restarts, and the first `valid` comes only after two rises.
- `enable` deasserted mid-period → no `valid`; `locked` = 0; `ratio`/`high_cnt` keep their last values. Re-enable → normal measurement resumes.

Source files
------------

// File: rtl/clock_ratio_pkg.sv
// Shared types and default parameters for the clock ratio meter.
package clock_ratio_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_WIDTH       = 32;
    localparam int DEF_TIMEOUT     = 2**20;

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronises an asynchronous level into clk_in and flags its rising edges.
module sync_rise_detect
    import clock_ratio_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period and high time of a divided clock in clk_in cycles,
// with lock detection on repeated measurements and loss-of-activity timeout.
module clock_ratio_meter
    import clock_ratio_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] ratio,
    output logic [WIDTH-1:0] high_cnt,
    output logic             valid,
    output logic             locked,
    output logic             timeout,
    output logic [1:0]       state_dbg
);

    localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // valid is a one-cycle strobe with no back-pressure: ratio/high_cnt are
    // stable from that cycle until the next strobe.

    state_t           state_q, state_d;
    logic [WIDTH-1:0] per_q, per_d, hi_q, hi_d;
    logic [WIDTH-1:0] ratio_d, high_d, per_inc;
    logic             valid_d, locked_d, timeout_d;
    logic             level, rise;

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .sig_in (sig_in),
        .level  (level),
        .rise   (rise)
    );

    assign per_inc   = per_q + ONE;
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        ratio_d   = ratio;
        high_d    = high_cnt;
        valid_d   = 1'b0;
        locked_d  = locked;
        timeout_d = timeout;
        case (state_q)
            IDLE: begin
                per_d     = '0;
                hi_d      = '0;
                locked_d  = 1'b0;
                timeout_d = 1'b0;
                state_d   = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                // First edge only opens a period; nothing to report yet.
                if (rise) begin
                    per_d     = ONE;
                    hi_d      = ONE;
                    timeout_d = 1'b0;
                    state_d   = MEASURE;
                end else if (per_q != TMO) begin
                    per_d = per_inc;
                    if (per_inc == TMO) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                    end
                end
            end
            MEASURE: begin
                if (rise) begin
                    ratio_d  = per_q;
                    high_d   = hi_q;
                    valid_d  = 1'b1;
                    locked_d = (per_q == ratio) && (hi_q == high_cnt);
                    per_d    = ONE;
                    hi_d     = ONE;
                end else if (per_inc == TMO) begin
                    per_d     = TMO;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = WAIT_EDGE;
                end else begin
                    per_d = per_inc;
                    hi_d  = hi_q + {{(WIDTH-1){1'b0}}, level};
                end
            end
            default: state_d = IDLE;
        endcase
        // Disable overrides everything, including a coincident rise.
        if (!enable) begin
            state_d   = IDLE;
            per_d     = '0;
            hi_d      = '0;
            ratio_d   = ratio;
            high_d    = high_cnt;
            valid_d   = 1'b0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            per_q    <= '0;
            hi_q     <= '0;
            ratio    <= '0;
            high_cnt <= '0;
            valid    <= 1'b0;
            locked   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            ratio    <= ratio_d;
            high_cnt <= high_d;
            valid    <= valid_d;
            locked   <= locked_d;
            timeout  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter: divider ratios, lock, timeout,
// async reset and enable handling, with hand-computed expectations.
module tb_clock_ratio_meter;

    localparam int W   = 16;
    localparam int TMO = 64;

    logic         clk_in = 1'b0;
    logic         reset;
    logic         enable;
    logic         sig_in;
    logic [W-1:0] ratio;
    logic [W-1:0] high_cnt;
    logic         valid;
    logic         locked;
    logic         timeout;
    logic [1:0]   state_dbg;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_valid;
    int   last_rise_cyc;
    int   r2;
    int   nv;
    logic lk_q[$];
    int   vc_q[$];

    clock_ratio_meter #(.SYNC_STAGES(2), .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .sig_in    (sig_in),
        .ratio     (ratio),
        .high_cnt  (high_cnt),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk_in cycle: sample outputs at the falling edge, then drive sig_in.
    task automatic step(input logic s);
        @(negedge clk_in);
        cyc++;
        if (valid === 1'b1) begin
            n_valid++;
            lk_q.push_back(locked);
            vc_q.push_back(cyc);
        end
        sig_in = s;
    endtask

    task automatic run_period(input int n);
        int hi;
        hi = n - n / 2;
        last_rise_cyc = cyc + 1;
        for (int i = 0; i < n; i++) step(i < hi);
    endtask

    task automatic clear_log();
        n_valid = 0;
        lk_q.delete();
        vc_q.delete();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        clear_log();
        repeat (3) @(negedge clk_in);
        chk("rst_ratio",   32'(ratio),    0);
        chk("rst_high",    32'(high_cnt), 0);
        chk("rst_valid",   32'(valid),    0);
        chk("rst_locked",  32'(locked),   0);
        chk("rst_timeout", 32'(timeout),  0);
        chk("rst_state",   32'(state_dbg), 0);
        reset = 1'b0;
        enable = 1'b1;
        step(0); step(0);

        // N=4 from idle: first rise opens, valids on rises 2..4
        clear_log();
        run_period(4);
        r2 = cyc + 1;
        run_period(4); run_period(4); run_period(4);
        chk("n4_count",   32'(n_valid), 3);
        chk("n4_latency", 32'(vc_q[0]), 32'(r2 + 3));
        chk("n4_spacing", 32'(vc_q[2] - vc_q[1]), 4);
        chk("n4_lk0",     32'(lk_q[0]), 0);
        chk("n4_lk1",     32'(lk_q[1]), 1);
        chk("n4_ratio",   32'(ratio),    4);
        chk("n4_high",    32'(high_cnt), 2);
        chk("n4_locked",  32'(locked),   1);

        // Switch to N=6: last 4-period closes locked, then drop, then relock
        clear_log();
        run_period(6); run_period(6); run_period(6);
        chk("n6_count",   32'(n_valid), 3);
        chk("n6_lk_drop", 32'(lk_q[1]), 0);
        chk("n6_lk_re",   32'(lk_q[2]), 1);
        chk("n6_spacing", 32'(vc_q[2] - vc_q[1]), 6);
        chk("n6_ratio",   32'(ratio),    6);
        chk("n6_high",    32'(high_cnt), 3);

        // N=5 (odd duty)
        clear_log();
        run_period(5); run_period(5); run_period(5);
        chk("n5_count",  32'(n_valid), 3);
        chk("n5_lk_drop", 32'(lk_q[1]), 0);
        chk("n5_ratio",  32'(ratio),    5);
        chk("n5_high",   32'(high_cnt), 3);
        chk("n5_locked", 32'(locked),   1);

        // N=2 (minimum ratio), then flush the last in-flight valid
        clear_log();
        run_period(2); run_period(2); run_period(2); run_period(2);
        step(0); step(0); step(0);
        chk("n2_count",  32'(n_valid), 4);
        chk("n2_ratio",  32'(ratio),    2);
        chk("n2_high",   32'(high_cnt), 1);
        chk("n2_locked", 32'(locked),   1);

        // Hold low: rise counted at edge after step c+2, timeout 63 edges later
        nv = n_valid;
        while (cyc < last_rise_cyc + 65) step(0);
        chk("tmo_before", 32'(timeout), 0);
        step(0);
        chk("tmo_assert", 32'(timeout), 1);
        chk("tmo_unlock", 32'(locked),  0);
        chk("tmo_state",  32'(state_dbg), 1);
        chk("tmo_novalid", 32'(n_valid), 32'(nv));
        run_period(4);
        chk("tmo_clear",   32'(timeout), 0);
        chk("tmo_rise_nv", 32'(n_valid), 32'(nv));
        chk("tmo_measure", 32'(state_dbg), 2);

        // Async reset mid-period
        run_period(4);
        chk("pre_rst_ratio", 32'(ratio), 4);
        step(1); step(1);
        #2;
        reset  = 1'b1;
        sig_in = 1'b0;
        #1;
        chk("arst_ratio",  32'(ratio),    0);
        chk("arst_high",   32'(high_cnt), 0);
        chk("arst_valid",  32'(valid),    0);
        chk("arst_locked", 32'(locked),   0);
        chk("arst_state",  32'(state_dbg), 0);
        @(negedge clk_in);
        reset = 1'b0;
        step(0); step(0); step(0);
        clear_log();
        run_period(4);
        chk("arst_first_nv", 32'(n_valid), 0);
        run_period(4); run_period(4);
        chk("arst_count",  32'(n_valid), 2);
        chk("arst_lk0",    32'(lk_q[0]), 0);
        chk("arst_locked", 32'(locked),  1);
        chk("arst_ratio4", 32'(ratio),   4);

        // Enable dropped before the pending rise is counted
        clear_log();
        step(1); step(1);
        enable = 1'b0;
        step(0); step(0); step(0); step(0);
        chk("dis_novalid", 32'(n_valid),  0);
        chk("dis_locked",  32'(locked),   0);
        chk("dis_ratio",   32'(ratio),    4);
        chk("dis_high",    32'(high_cnt), 2);
        chk("dis_state",   32'(state_dbg), 0);
        enable = 1'b1;
        step(0); step(0);
        run_period(5); run_period(5); run_period(5);
        chk("ren_count",  32'(n_valid), 2);
        chk("ren_lk0",    32'(lk_q[0]), 0);
        chk("ren_ratio",  32'(ratio),    5);
        chk("ren_high",   32'(high_cnt), 3);
        chk("ren_locked", 32'(locked),   1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
